spike_weight_streamer: RTL and testbench
========================================

SPIKE_WEIGHT_STREAMER -- requirements
Module: spike_weight_streamer

Interface
REQ-001 Parameter NIN, default 16, number of presynaptic inputs per timestep.
REQ-002 Parameter SYNWID, default 8, synaptic weight width.
REQ-003 Parameter AWID, default 4, weight address width; SHALL satisfy 2**AWID >= NIN.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  begin one timestep; honoured only in IDLE.
REQ-007 spikes  in  NIN  presynaptic spike vector; bit i = input i fired; sampled with start.
REQ-008 mem_en  out  1  weight-memory read enable.
REQ-009 mem_addr  out  AWID  weight-memory read address.
REQ-010 mem_rdata  in  SYNWID  weight; valid exactly one cycle after mem_en.
REQ-011 clr  out  1  accumulator clear pulse.
REQ-012 valid  out  1  weight beat to accumulator.
REQ-013 data  out  SYNWID  weight value; equals mem_rdata when valid=1, else 0.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse; the accumulator holds the final sum.
REQ-016 cnt  out  AWID+1  number of valid beats issued this timestep.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, SCAN, DRAIN, DONE.
REQ-018 IDLE: on start=1, latch spikes into an internal shadow register, zero cnt, go to CLEAR; start=0 stays in IDLE.
REQ-019 CLEAR: clr=1 for exactly this one cycle; index counter set to 0; next state is SCAN.
REQ-020 SCAN: exactly NIN cycles, index 0..NIN-1 in order, one index per cycle.
REQ-021 SCAN, shadow bit set: mem_en=1, mem_addr=index.
REQ-022 SCAN, shadow bit clear: mem_en=0, mem_addr=0.
REQ-023 After index NIN-1, the next state is DRAIN (one cycle), then DONE (one cycle, done=1), then IDLE.
REQ-024 valid SHALL be mem_en delayed by one register stage; data SHALL be gated to 0 when valid=0.
REQ-025 cnt SHALL increment on every cycle with valid=1 and hold its value until the next accepted start.
REQ-026 Latency SHALL be fixed regardless of spike pattern: start sampled at edge of cycle 0 -> clr in cycle 1, SCAN in cycles 2..NIN+1, DRAIN in NIN+2, done in NIN+3.
REQ-027 The last possible valid SHALL occur in DRAIN, so the accumulator is final when done=1.
REQ-028 start while busy=1 (including the DONE cycle) SHALL be ignored, with no effect on shadow, cnt or sequence.
REQ-029 spikes changes after the start cycle SHALL NOT affect the current timestep.
REQ-030 All-zero spikes: clr and done still issued with normal latency; no valid; cnt=0.
REQ-031 clr and valid SHALL never be high in the same cycle; mem_en SHALL never be high outside SCAN.

Reset
REQ-032 rst_n=0 SHALL immediately force all of the following to 0 and the FSM to IDLE: mem_en, mem_addr, clr, valid, data, busy, done, cnt, shadow, index.
REQ-033 Reset mid-timestep SHALL abort it with no done pulse; the first start after release SHALL run a full normal sequence.

Verification (NIN=16, SYNWID=8, memory model weight[i]=i+1, results checked with an accumulator attached)
REQ-034 spikes=16'h0001, start in cycle 0 -> clr in cycle 1, single valid data=1 in cycle 3, done in cycle 19, acc=1, cnt=1.
REQ-035 spikes=16'hFFFF -> valid high in cycles 3..18, data 1..16 in order, done in cycle 19, acc=136, cnt=16.
REQ-036 spikes=16'h8000 -> single valid data=16 in cycle 18 (DRAIN), done in cycle 19, acc=16.
REQ-037 spikes=16'h0000 -> clr in cycle 1, no valid, done in cycle 19, acc=0, cnt=0.
REQ-038 start pulsed in cycles 5 and 19 of a running timestep -> ignored, exactly one done; second timestep starts only on the start in cycle 20.
REQ-039 rst_n low during SCAN (cycle 8) -> all outputs 0 immediately, no done; next start with 16'h00F0 -> acc=5+6+7+8=26.

Source files
------------

// File: rtl/spike_weight_streamer.sv
// Walks a latched spike vector one input per cycle, reading the weight of every
// fired input and streaming it to a downstream accumulator with a fixed latency.
module spike_weight_streamer #(
  parameter int NIN    = 16,
  parameter int SYNWID = 8,
  parameter int AWID   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [NIN-1:0]    spikes_i,
  output logic              mem_en_o,
  output logic [AWID-1:0]   mem_addr_o,
  input  logic [SYNWID-1:0] mem_rdata_i,
  output logic              clr_o,
  output logic              valid_o,
  output logic [SYNWID-1:0] data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [AWID:0]     cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    DRAIN,
    DONE
  } state_e;

  localparam logic [AWID-1:0] LAST_IDX = AWID'(NIN - 1);

  state_e            state_q;
  logic [NIN-1:0]    shadow_q;
  logic [AWID-1:0]   idx_q;
  logic [AWID-1:0]   idx_d;
  logic              mem_en_q;
  logic [AWID-1:0]   mem_addr_q;
  logic              clr_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [AWID:0]     cnt_q;

  assign idx_d = idx_q + AWID'(1);

  // The read request for index k is registered one cycle ahead, so the
  // memory strobe lines up with the SCAN cycle that owns index k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      clr_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      valid_q <= mem_en_q;
      if (valid_q) begin
        cnt_q <= cnt_q + (AWID+1)'(1);
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            shadow_q <= spikes_i;
            cnt_q    <= '0;
            clr_q    <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= CLEAR;
          end
        end
        CLEAR: begin
          clr_q      <= 1'b0;
          idx_q      <= '0;
          mem_en_q   <= shadow_q[0];
          mem_addr_q <= '0;
          state_q    <= SCAN;
        end
        SCAN: begin
          if (idx_q == LAST_IDX) begin
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            state_q    <= DRAIN;
          end else begin
            idx_q      <= idx_d;
            mem_en_q   <= shadow_q[idx_d];
            mem_addr_q <= shadow_q[idx_d] ? idx_d : '0;
          end
        end
        DRAIN: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_en_o   = mem_en_q;
  assign mem_addr_o = mem_addr_q;
  assign clr_o      = clr_q;
  assign valid_o    = valid_q;
  assign data_o     = valid_q ? mem_rdata_i : '0;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign cnt_o      = cnt_q;

endmodule

// File: tb/tb_spike_weight_streamer.sv
// Directed scoreboard bench: each timestep pushes its expected clr, weight beats
// and done/accumulator result, which a negedge monitor pops and compares.
module tb_spike_weight_streamer;

  localparam int NIN    = 16;
  localparam int SYNWID = 8;
  localparam int AWID   = 4;

  typedef struct {
    int cyc;
    int val;
  } beat_t;

  typedef struct {
    int cyc;
    int acc;
    int cnt;
  } done_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [NIN-1:0]    spikes = '0;
  logic              mem_en;
  logic [AWID-1:0]   mem_addr;
  logic [SYNWID-1:0] mem_rdata = '0;
  logic              clr;
  logic              valid;
  logic [SYNWID-1:0] data;
  logic              busy;
  logic              done;
  logic [AWID:0]     cnt;

  int    cyc = 0;
  int    t0 = 0;
  int    acc = 0;
  int    total = 0;
  int    bad = 0;
  int    clrQ[$];
  beat_t beatQ[$];
  done_t doneQ[$];

  spike_weight_streamer #(.NIN(NIN), .SYNWID(SYNWID), .AWID(AWID)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .spikes_i   (spikes),
    .mem_en_o   (mem_en),
    .mem_addr_o (mem_addr),
    .mem_rdata_i(mem_rdata),
    .clr_o      (clr),
    .valid_o    (valid),
    .data_o     (data),
    .busy_o     (busy),
    .done_o     (done),
    .cnt_o      (cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory holds weight[i] = i+1; unread cycles return a junk pattern
  // so that missing output gating is visible.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= SYNWID'(int'(mem_addr) + 1);
    else        mem_rdata <= 8'hAA;
  end

  // Monitor: accumulates the beat stream and pops expectations as outputs appear.
  always @(negedge clk) begin
    beat_t b;
    done_t d;
    int    c;
    if (rst_n) begin
      total++;
      assert ((valid || data == '0) && (mem_en || mem_addr == '0))
      else begin
        bad++;
        $error("[TB] FAIL gating cyc=%0d valid=%0b data=%0h en=%0b addr=%0h required data=0/addr=0 when idle",
               cyc, valid, data, mem_en, mem_addr);
      end
      if (clr) begin
        acc = 0;
        c = (clrQ.size() > 0) ? clrQ.pop_front() : -1;
        total++;
        assert (c == cyc && !valid)
        else begin
          bad++;
          $error("[TB] FAIL clr cyc=%0d valid=%0b required cyc=%0d valid=0", cyc, valid, c);
        end
      end
      if (valid) begin
        acc += int'(data);
        if (beatQ.size() > 0) b = beatQ.pop_front();
        else b = '{cyc: -1, val: -1};
        total++;
        assert (b.cyc == cyc && b.val == int'(data))
        else begin
          bad++;
          $error("[TB] FAIL beat cyc=%0d data=%0d required cyc=%0d data=%0d", cyc, data, b.cyc, b.val);
        end
      end
      if (done) begin
        if (doneQ.size() > 0) d = doneQ.pop_front();
        else d = '{cyc: -1, acc: -1, cnt: -1};
        total++;
        assert (d.cyc == cyc && d.acc == acc && d.cnt == int'(cnt) && busy)
        else begin
          bad++;
          $error("[TB] FAIL done cyc=%0d acc=%0d cnt=%0d busy=%0b required cyc=%0d acc=%0d cnt=%0d busy=1",
                 cyc, acc, cnt, busy, d.cyc, d.acc, d.cnt);
        end
      end
    end
  end

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) waitCycle();
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    assert (actual === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s got=%0d required=%0d", tag, actual, expected);
    end
  endtask

  // Drives start for one cycle and records what the timestep must produce.
  task automatic applyStimulus(input logic [NIN-1:0] s);
    int expAcc = 0;
    int expCnt = 0;
    waitCycle();
    t0 = cyc;
    start = 1'b1;
    spikes = s;
    clrQ.push_back(t0 + 1);
    for (int i = 0; i < NIN; i++) begin
      if (s[i]) begin
        beatQ.push_back('{cyc: t0 + 3 + i, val: i + 1});
        expAcc += i + 1;
        expCnt++;
      end
    end
    doneQ.push_back('{cyc: t0 + NIN + 3, acc: expAcc, cnt: expCnt});
    waitCycle();
    start = 1'b0;
    spikes = NIN'($urandom);
  endtask

  task automatic drainScoreboard(input int maxCycles);
    int n = 0;
    while ((clrQ.size() + beatQ.size() + doneQ.size()) != 0 && n < maxCycles) begin
      waitCycle();
      n++;
    end
    total++;
    assert ((clrQ.size() + beatQ.size() + doneQ.size()) == 0)
    else begin
      bad++;
      $error("[TB] FAIL timeout pending=%0d required=0", clrQ.size() + beatQ.size() + doneQ.size());
    end
  endtask

  initial begin
    #2;
    checkOutput("reset_outputs",
                int'({mem_en, mem_addr, clr, valid, data, busy, done, cnt}), 0);
    waitCycle();
    waitCycle();
    rst_n = 1'b1;
    waitCycle();

    $display("[TB] single spike on input 0");
    applyStimulus(16'h0001);
    drainScoreboard(40);
    checkOutput("idle_after_done", int'(busy), 0);
    waitCycle();
    waitCycle();
    checkOutput("cnt_hold", int'(cnt), 1);

    $display("[TB] all inputs firing");
    applyStimulus(16'hFFFF);
    drainScoreboard(40);

    $display("[TB] only the last input firing");
    applyStimulus(16'h8000);
    drainScoreboard(40);

    $display("[TB] no spikes");
    applyStimulus(16'h0000);
    drainScoreboard(40);
    checkOutput("cnt_zero", int'(cnt), 0);

    $display("[TB] start while busy is ignored");
    applyStimulus(16'hFFFF);
    waitUntil(t0 + 5);
    start = 1'b1;
    spikes = 16'h0000;
    waitCycle();
    start = 1'b0;
    waitUntil(t0 + 19);
    checkOutput("busy_in_done", int'(busy), 1);
    start = 1'b1;
    spikes = 16'h0000;
    applyStimulus(16'h0003);
    drainScoreboard(60);

    $display("[TB] reset during scan");
    applyStimulus(16'hFFFF);
    waitUntil(t0 + 8);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_outputs",
                int'({mem_en, mem_addr, clr, valid, data, busy, done, cnt}), 0);
    clrQ.delete();
    beatQ.delete();
    doneQ.delete();
    waitCycle();
    waitCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) waitCycle();
    applyStimulus(16'h00F0);
    drainScoreboard(40);
    checkOutput("cnt_after_reset", int'(cnt), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
